// File: rtl/gate_sweep_ctrl.sv
// Sweeps a 2-input gate network through {x,y} = 00..11 and captures its truth table.
// Define SWEEP_CHECK_EN to compile in the expected-table self-check that drives err.
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       s_i,
    output logic       x_o,
    output logic       y_o,
    output logic [2:0] op_o,
    output logic       busy,
    output logic       done,
    output logic [3:0] table_o,
    output logic       err
);

    typedef enum logic [1:0] {StIdle, StApply, StSample, StDone} state_e;

    state_e     state;
    logic [1:0] idx;
    logic [1:0] nextIdx;
    logic [3:0] settleCnt;
    logic [3:0] capTable;
    logic       accept;

    assign accept  = (state == StIdle) && start && (op <= 3'd5);
    assign nextIdx = idx + 2'd1;

    // Table as it will look once the current sample is written in.
    always_comb begin
        capTable      = table_o;
        capTable[idx] = s_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            idx       <= 2'd0;
            settleCnt <= 4'd0;
            x_o       <= 1'b0;
            y_o       <= 1'b0;
            op_o      <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_o   <= 4'b0000;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        state     <= StApply;
                        idx       <= 2'd0;
                        settleCnt <= 4'd0;
                        op_o      <= op;
                        table_o   <= 4'b0000;
                        busy      <= 1'b1;
                        x_o       <= 1'b0;
                        y_o       <= 1'b0;
                    end
                end
                StApply: begin
                    if (settleCnt == 4'(SETTLE - 1)) begin
                        settleCnt <= 4'd0;
                        state     <= StSample;
                    end else begin
                        settleCnt <= settleCnt + 4'd1;
                    end
                end
                StSample: begin
                    table_o <= capTable;
                    if (idx == 2'd3) begin
                        state <= StDone;
                        idx   <= 2'd0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        x_o   <= 1'b0;
                        y_o   <= 1'b0;
                    end else begin
                        idx   <= nextIdx;
                        x_o   <= nextIdx[1];
                        y_o   <= nextIdx[0];
                        state <= StApply;
                    end
                end
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

`ifdef SWEEP_CHECK_EN
    logic errQ;

    function automatic logic [3:0] expectedTable(input logic [2:0] sel);
        case (sel)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b1110;
            3'd2:    return 4'b0110;
            3'd3:    return 4'b0011;
            3'd4:    return 4'b0111;
            3'd5:    return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    // Flag is computed on the final sample edge so it is valid alongside done.
    always_ff @(posedge clk) begin
        if (reset) begin
            errQ <= 1'b0;
        end else if (accept) begin
            errQ <= 1'b0;
        end else if (state == StSample && idx == 2'd3) begin
            errQ <= (capTable != expectedTable(op_o));
        end
    end

    assign err = errQ;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Scoreboard bench for gate_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) driven
// by a behavioural gate network; expected tables come from the bench's own gate model.
module tb_gate_sweep_ctrl;

    logic       clk = 1'b0;
    logic       reset, startA, startB, faulty;
    logic [2:0] op;

    logic       xA, yA, busyA, doneA, errA, sA;
    logic [2:0] opOA;
    logic [3:0] tableA;
    logic       xB, yB, busyB, doneB, errB, sB;
    logic [2:0] opOB;
    logic [3:0] tableB;

    typedef struct packed {
        logic [3:0] tbl;
        logic       err;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    logic sel    = 1'b0;

    always #5 clk = ~clk;

    function automatic logic gateRef(input logic [2:0] o, input logic x, input logic y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~x;
            3'd4:    return ~(x & y);
            3'd5:    return ~(x | y);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] expTable(input logic [2:0] o);
        logic [3:0] t;
        logic [1:0] v;
        for (int i = 0; i < 4; i++) begin
            v    = 2'(i);
            t[i] = gateRef(o, v[1], v[0]);
        end
        return t;
    endfunction

    // External gate network under test; faulty forces a stuck-at-1 output.
    assign sA = faulty ? 1'b1 : gateRef(opOA, xA, yA);
    assign sB = faulty ? 1'b1 : gateRef(opOB, xB, yB);

    gate_sweep_ctrl #(.SETTLE(1)) dutA (
        .clk(clk), .reset(reset), .start(startA), .op(op), .s_i(sA),
        .x_o(xA), .y_o(yA), .op_o(opOA), .busy(busyA), .done(doneA),
        .table_o(tableA), .err(errA)
    );

    gate_sweep_ctrl #(.SETTLE(3)) dutB (
        .clk(clk), .reset(reset), .start(startB), .op(op), .s_i(sB),
        .x_o(xB), .y_o(yB), .op_o(opOB), .busy(busyB), .done(doneB),
        .table_o(tableB), .err(errB)
    );

    logic       xS, yS, busyS, doneS, errS;
    logic [2:0] opS;
    logic [3:0] tableS;
    assign xS     = sel ? xB : xA;
    assign yS     = sel ? yB : yA;
    assign busyS  = sel ? busyB : busyA;
    assign doneS  = sel ? doneB : doneA;
    assign errS   = sel ? errB : errA;
    assign opS    = sel ? opOB : opOA;
    assign tableS = sel ? tableB : tableA;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic expErr(input logic [3:0] tbl, input logic [2:0] o);
`ifdef SWEEP_CHECK_EN
        return tbl != expTable(o);
`else
        return 1'b0;
`endif
    endfunction

    task automatic popCompare(input logic [3:0] gotTbl, input logic gotErr);
        exp_t e;
        if (expQ.size() == 0) begin
            checkVal("spurious_done", 1, 0);
        end else begin
            e = expQ.pop_front();
            checkVal("table", gotTbl, e.tbl);
            checkVal("err", gotErr, e.err);
        end
    endtask

    task automatic runSweep(input logic useB, input logic [2:0] o, input logic bad);
        int   s   = useB ? 3 : 1;
        int   lat = 4 * (s + 1);
        int   n   = 0;
        int   busyCnt = 0;
        bit   seenDone = 0;
        bit   vecOk = 1;
        exp_t e;
        sel    = useB;
        faulty = bad;
        op     = o;
        if (useB) startB = 1'b1;
        else startA = 1'b1;
        @(posedge clk);
        #1;
        startA = 1'b0;
        startB = 1'b0;
        e.tbl  = bad ? 4'hF : expTable(o);
        e.err  = expErr(e.tbl, o);
        expQ.push_back(e);
        op = (o == 3'd1) ? 3'd2 : 3'd1;
        while (n <= lat + 4 && !seenDone) begin
            @(negedge clk);
            if (n == 0) begin
                checkVal("clr_table", tableS, 0);
                checkVal("clr_err", errS, 0);
            end
            if (doneS) begin
                seenDone = 1;
            end else begin
                if (busyS) busyCnt++;
                if ({xS, yS} != 2'(n / (s + 1))) vecOk = 0;
                @(posedge clk);
                n++;
            end
        end
        if (!seenDone) begin
            checkVal("done_timeout", 0, 1);
            void'(expQ.pop_front());
        end else begin
            popCompare(tableS, errS);
            checkVal("latency", n, lat);
            checkVal("busy_cycles", busyCnt, lat);
            checkVal("vec_order", vecOk, 1);
            checkVal("busy_at_done", busyS, 0);
            checkVal("op_latched", opS, o);
            @(negedge clk);
            checkVal("done_pulse", doneS, 0);
            checkVal("idle_xy", {xS, yS}, 0);
        end
        faulty = 1'b0;
    endtask

    initial begin
        int doneCnt, firstDone, secondDone, busyHigh;
        bit doneSeen;
        reset  = 1'b1;
        startA = 1'b0;
        startB = 1'b0;
        faulty = 1'b0;
        op     = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVal("rst_busy", busyA, 0);
        checkVal("rst_done", doneA, 0);
        checkVal("rst_table", tableA, 0);
        checkVal("rst_err", errA, 0);
        checkVal("rst_op", opOA, 0);
        checkVal("rst_xy", {xA, yA}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        runSweep(1'b0, 3'd2, 1'b0);
        runSweep(1'b0, 3'd4, 1'b1);
        runSweep(1'b0, 3'd0, 1'b0);
        runSweep(1'b1, 3'd5, 1'b0);
        runSweep(1'b0, 3'd3, 1'b0);
        runSweep(1'b0, 3'd1, 1'b0);

        // start held high: two sweeps separated by one IDLE cycle
        sel     = 1'b0;
        op      = 3'd2;
        startA  = 1'b1;
        doneCnt = 0;
        firstDone  = -1;
        secondDone = -1;
        @(posedge clk);
        expQ.push_back('{tbl: 4'b0110, err: 1'b0});
        expQ.push_back('{tbl: 4'b0110, err: 1'b0});
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (doneA) begin
                doneCnt++;
                if (doneCnt == 1) firstDone = n;
                else if (doneCnt == 2) secondDone = n;
                popCompare(tableA, errA);
                if (doneCnt == 2) startA = 1'b0;
            end
            @(posedge clk);
        end
        checkVal("held_done_cnt", doneCnt, 2);
        checkVal("held_first", firstDone, 8);
        checkVal("held_second", secondDone, 18);
        @(negedge clk);
        checkVal("held_idle", busyA, 0);
        startA = 1'b0;
        expQ.delete();

        // illegal op ignored
        op       = 3'd6;
        startA   = 1'b1;
        busyHigh = 0;
        repeat (4) begin
            @(negedge clk);
            if (busyA) busyHigh++;
        end
        startA = 1'b0;
        checkVal("illegal_busy", busyHigh, 0);

        // reset during vector idx=2 aborts without done
        op     = 3'd2;
        startA = 1'b1;
        @(posedge clk);
        #1 startA = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkVal("pre_rst_xy", {xA, yA}, 2'b10);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkVal("abort_busy", busyA, 0);
        checkVal("abort_table", tableA, 0);
        checkVal("abort_xy", {xA, yA}, 0);
        checkVal("abort_done", doneA, 0);
        doneSeen = 0;
        repeat (12) begin
            @(negedge clk);
            if (doneA) doneSeen = 1;
        end
        checkVal("abort_no_done", doneSeen, 0);

        runSweep(1'b0, 3'd2, 1'b0);
        runSweep(1'b0, 3'd5, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
